// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and target FSM state encodings.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W    = 7;
  localparam int unsigned I2C_BYTE_W    = 8;
  localparam int unsigned I2C_BIT_CNT_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus registered edge and START/STOP detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d;
  logic sda_hist_q, sda_hist_d;
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_det_q, start_det_d;
  logic stop_det_q, stop_det_d;
  logic sda_s_q, sda_s_d;
  logic scl_cur_c, sda_cur_c;

  assign scl_cur_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_cur_c = sda_sync_q[SYNC_STAGES-1];

  // Events are registered so sda_s and the edge flags stay cycle-aligned.
  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d  = scl_cur_c;
    sda_hist_d  = sda_cur_c;
    scl_rise_d  = scl_cur_c & ~scl_hist_q;
    scl_fall_d  = ~scl_cur_c & scl_hist_q;
    start_det_d = scl_cur_c & scl_hist_q & sda_hist_q & ~sda_cur_c;
    stop_det_d  = scl_cur_c & scl_hist_q & ~sda_hist_q & sda_cur_c;
    sda_s_d     = sda_cur_c;
  end

  // Idle bus reads high, so history resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      scl_rise_q  <= 1'b0;
      scl_fall_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      sda_s_q     <= 1'b1;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      scl_rise_q  <= scl_rise_d;
      scl_fall_q  <= scl_fall_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      sda_s_q     <= sda_s_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign sda_s     = sda_s_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target with 8-bit auto-incrementing register pointer and a single-port regfile interface.
module i2c_target_regif
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] reg_addr,
  output logic [I2C_BYTE_W-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [I2C_BYTE_W-1:0] reg_rdata,
  output logic                  busy
);

  localparam logic [I2C_BIT_CNT_W-1:0] LAST_BIT = I2C_BIT_CNT_W'(I2C_BYTE_W - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_e             state_q, state_d;
  logic [I2C_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]      shift_q, shift_d;
  logic [I2C_BYTE_W-1:0]      reg_addr_q, reg_addr_d;
  logic [I2C_BYTE_W-1:0]      reg_wdata_q, reg_wdata_d;
  logic                       sda_oe_q, sda_oe_d;
  logic                       reg_we_q, reg_we_d;
  logic                       reg_re_q, reg_re_d;
  logic                       busy_q, busy_d;
  logic                       rw_q, rw_d;
  logic                       phase_q, phase_d;
  logic                       ld_q, ld_d;
  logic [I2C_BYTE_W-1:0]      rx_byte_c;

  assign rx_byte_c = {shift_q[I2C_BYTE_W-2:0], sda_s};

  // phase_q: in ACK states, 1 once SDA is driven; in RDATA_ACK, 1 once master ACK seen.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    sda_oe_d    = sda_oe_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    ld_d        = reg_re_q;

    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;
    if (ld_q)     shift_d    = reg_rdata;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            phase_d   = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte_c[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte_c[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else if (state_q == ST_PTR) begin
                reg_addr_d = rx_byte_c;
                state_d    = ST_PTR_ACK;
              end else begin
                reg_wdata_d = rx_byte_c;
                reg_we_d    = 1'b1;
                state_d     = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q) reg_re_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_RDATA;
                sda_oe_d = ~shift_q[I2C_BYTE_W-1];
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_d = ~shift_q[I2C_BYTE_W-2];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_s) begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end else begin
                phase_d    = 1'b1;
                reg_addr_d = reg_addr_q + 8'd1;
                reg_re_d   = 1'b1;
              end
            end
          end else if (scl_fall) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_RDATA;
            sda_oe_d  = ~shift_q[I2C_BYTE_W-1];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      sda_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      sda_oe_q    <= sda_oe_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      ld_q        <= ld_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: bus master tasks, regfile model, strobe logs.
module tb_i2c_target_regif;

  localparam int unsigned QT = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_in;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re, busy;
  logic [7:0] reg_rdata = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] we_a[$];
  logic [7:0] we_d[$];
  logic [7:0] re_a[$];
  int unsigned oe_cnt   = 0;
  int unsigned busy_cnt = 0;
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target.
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_regif #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register file with one-clock read latency, plus strobe logging.
  always @(posedge clk) begin
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_d.push_back(reg_wdata);
    end
    if (reg_re) begin
      re_a.push_back(reg_addr);
      reg_rdata <= mem[reg_addr];
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] qget(input logic [7:0] qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return 8'hxx;
  endfunction

  task automatic qt(input int unsigned n = 1);
    repeat (n * QT) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qt();
    scl_in = 1'b1; qt();
    sda_m = 1'b0; qt();
    scl_in = 1'b0; qt();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qt();
    scl_in = 1'b1; qt();
    sda_m = 1'b1; qt();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b; qt();
    scl_in = 1'b1; qt();
    s = sda_in; qt();
    scl_in = 1'b0; qt();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic nak);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, nak);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(mack, s);
  endtask

  initial begin
    logic       nak;
    logic [7:0] rd;
    int wb, rb;
    int unsigned ob, bb;

    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'hC3;
    rst_n = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
    qt(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    qt(2);

    // 1: write two bytes from pointer 0x10
    wb = we_a.size();
    bus_start();
    send_byte(8'h84, nak); chk("t1_addr_ack", nak, 0);
    chk("t1_busy_mid", busy, 1);
    send_byte(8'h10, nak); chk("t1_ptr_ack", nak, 0);
    send_byte(8'hA5, nak); chk("t1_d0_ack", nak, 0);
    send_byte(8'h5A, nak); chk("t1_d1_ack", nak, 0);
    bus_stop(); qt(2);
    chk("t1_busy_end", busy, 0);
    chk("t1_we_cnt", we_a.size() - wb, 2);
    chk("t1_we0_addr", qget(we_a, wb), 8'h10);
    chk("t1_we0_data", qget(we_d, wb), 8'hA5);
    chk("t1_we1_addr", qget(we_a, wb + 1), 8'h11);
    chk("t1_we1_data", qget(we_d, wb + 1), 8'h5A);
    chk("t1_reg_addr", reg_addr, 8'h12);

    // 2: pointer write, repeated START, two-byte read
    wb = we_a.size(); rb = re_a.size();
    bus_start();
    send_byte(8'h84, nak); chk("t2_addr_ack", nak, 0);
    send_byte(8'h20, nak); chk("t2_ptr_ack", nak, 0);
    bus_start();
    send_byte(8'h85, nak); chk("t2_raddr_ack", nak, 0);
    read_byte(1'b0, rd); chk("t2_rd0", rd, 8'h3C);
    read_byte(1'b1, rd); chk("t2_rd1", rd, 8'hC3);
    bus_stop(); qt(2);
    chk("t2_re_cnt", re_a.size() - rb, 2);
    chk("t2_re0_addr", qget(re_a, rb), 8'h20);
    chk("t2_re1_addr", qget(re_a, rb + 1), 8'h21);
    chk("t2_we_cnt", we_a.size() - wb, 0);
    chk("t2_busy_end", busy, 0);

    // 3: address mismatch, target must stay silent
    wb = we_a.size(); ob = oe_cnt; bb = busy_cnt;
    bus_start();
    send_byte(8'h86, nak); chk("t3_addr_nak", nak, 1);
    send_byte(8'h11, nak); chk("t3_data_nak", nak, 1);
    bus_stop(); qt(2);
    chk("t3_oe_cycles", oe_cnt - ob, 0);
    chk("t3_busy_cycles", busy_cnt - bb, 0);
    chk("t3_we_cnt", we_a.size() - wb, 0);

    // 4: pointer wraps from 0xFF to 0x00
    wb = we_a.size();
    bus_start();
    send_byte(8'h84, nak); chk("t4_addr_ack", nak, 0);
    send_byte(8'hFF, nak); chk("t4_ptr_ack", nak, 0);
    send_byte(8'h01, nak); chk("t4_d0_ack", nak, 0);
    send_byte(8'h02, nak); chk("t4_d1_ack", nak, 0);
    bus_stop(); qt(2);
    chk("t4_we_cnt", we_a.size() - wb, 2);
    chk("t4_we0_addr", qget(we_a, wb), 8'hFF);
    chk("t4_we0_data", qget(we_d, wb), 8'h01);
    chk("t4_we1_addr", qget(we_a, wb + 1), 8'h00);
    chk("t4_we1_data", qget(we_d, wb + 1), 8'h02);
    chk("t4_reg_addr", reg_addr, 8'h01);

    // 5: STOP after four data bits discards the byte
    wb = we_a.size();
    bus_start();
    send_byte(8'h84, nak); chk("t5_addr_ack", nak, 0);
    send_byte(8'h30, nak); chk("t5_ptr_ack", nak, 0);
    send_bit(1'b1, nak); send_bit(1'b0, nak); send_bit(1'b1, nak); send_bit(1'b0, nak);
    bus_stop(); qt(2);
    chk("t5_abort_we_cnt", we_a.size() - wb, 0);
    chk("t5_abort_busy", busy, 0);
    bus_start();
    send_byte(8'h84, nak); chk("t5_next_addr_ack", nak, 0);
    send_byte(8'h40, nak); chk("t5_next_ptr_ack", nak, 0);
    send_byte(8'h77, nak); chk("t5_next_d_ack", nak, 0);
    bus_stop(); qt(2);
    chk("t5_we_cnt", we_a.size() - wb, 1);
    chk("t5_we_addr", qget(we_a, wb), 8'h40);
    chk("t5_we_data", qget(we_d, wb), 8'h77);

    // 6: async reset while driving a 0 read bit
    mem[8'h41] = 8'h00;
    bus_start();
    send_byte(8'h85, nak); chk("t6_addr_ack", nak, 0);
    chk("t6_oe_pre", sda_oe, 1);
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sda_oe", sda_oe, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_reg_addr", reg_addr, 0);
    chk("t6_rst_reg_we", reg_we, 0);
    chk("t6_rst_reg_re", reg_re, 0);
    chk("t6_rst_reg_wdata", reg_wdata, 0);
    qt();
    rst_n = 1'b1;
    sda_m = 1'b1; qt();
    scl_in = 1'b1; qt(2);
    wb = we_a.size();
    bus_start();
    send_byte(8'h84, nak); chk("t6_post_addr_ack", nak, 0);
    send_byte(8'h50, nak); chk("t6_post_ptr_ack", nak, 0);
    send_byte(8'h99, nak); chk("t6_post_d_ack", nak, 0);
    bus_stop(); qt(2);
    chk("t6_we_cnt", we_a.size() - wb, 1);
    chk("t6_we_addr", qget(we_a, wb), 8'h50);
    chk("t6_we_data", qget(we_d, wb), 8'h99);
    chk("t6_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
